// File: rtl/operand_fetch_sequencer_pkg.sv
// Shared definitions for the operand fetch sequencer and the decoder that
// drives it: state encoding and the need_imm codes.
package operand_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_DISP = 3'd1,
        F_LO   = 3'd2,
        F_HI   = 3'd3,
        FIN    = 3'd4
    } opseq_state_t;

    localparam logic [1:0] NEED_IMM_NONE = 2'd0;
    localparam logic [1:0] NEED_IMM_N    = 2'd1;
    localparam logic [1:0] NEED_IMM_NN   = 2'd2;

    // A low immediate byte is fetched for any non-zero code.
    function automatic logic imm_has_lo(input logic [1:0] need);
        return need != NEED_IMM_NONE;
    endfunction

    // Code 3 is an alias of NN, so anything >= NN fetches the high byte.
    function automatic logic imm_has_hi(input logic [1:0] need);
        return need >= NEED_IMM_NN;
    endfunction

endpackage

// File: rtl/operand_fetch_sequencer_byte_latch.sv
// opseq_byte_latch: one captured operand byte.
// Ports: clk, rst (sync, active high), clr (sync clear), en (capture d), d, q.
module opseq_byte_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) q <= 8'h00;
        else if (en)    q <= d;
    end

endmodule

// File: rtl/operand_fetch_sequencer.sv
// operand_fetch_sequencer: fetches the d / n / nn bytes following an opcode.
// Decode pulses start with the fetch requirements; the sequencer walks the
// read handshake one byte at a time, bumps the address per byte and pulses
// done with disp, imm and pc_out valid.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, need_disp,        request from decode (sampled only in IDLE)
//   need_imm, pc_in
//   mem_rd_req/addr/ack/data memory read handshake
//   pc_out, disp, imm        results, valid with done and held afterwards
//   busy, done, fetch_err    status
// Optional: define OPSEQ_TIMEOUT_EN to add a read watchdog of TIMEOUT_CYC
// cycles; without it fetch_err is tied low and reads wait forever.
module operand_fetch_sequencer
    import operand_fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              need_disp,
    input  logic [1:0]        need_imm,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [7:0]        mem_rd_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic [7:0]        disp,
    output logic [15:0]       imm,
    output logic              busy,
    output logic              done,
    output logic              fetch_err
);

    // The watchdog counter is 4 bits wide.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 1..15");
    end

    opseq_state_t      state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        nimm_q;
    logic              fetching;
    logic              lat_clr;
    logic [2:0]        lat_en;
    logic [2:0][7:0]   lat_q;     // [0]=d, [1]=lo, [2]=hi
    logic              timeout;

    // Last completed results; shown whenever we are not in FIN so that an
    // aborted fetch never disturbs what execute last saw.
    logic [ADDR_W-1:0] pc_hold;
    logic [7:0]        disp_hold;
    logic [15:0]       imm_hold;

`ifdef OPSEQ_TIMEOUT_EN
    logic [3:0] wd_cnt;
    logic       err_q;
`endif

    assign fetching = (state == F_DISP) || (state == F_LO) || (state == F_HI);

    always_comb begin
        state_n = state;
        lat_clr = 1'b0;
        lat_en  = 3'b000;
        timeout = 1'b0;
        case (state)
            IDLE: if (start) begin
                lat_clr = 1'b1;   // hi byte reads 0 for a single-byte immediate
                if (need_disp)                state_n = F_DISP;
                else if (imm_has_lo(need_imm)) state_n = F_LO;
                else                          state_n = FIN;
            end
            F_DISP: if (mem_rd_ack) begin
                lat_en[0] = 1'b1;
                state_n   = imm_has_lo(nimm_q) ? F_LO : FIN;
            end
            F_LO: if (mem_rd_ack) begin
                lat_en[1] = 1'b1;
                state_n   = imm_has_hi(nimm_q) ? F_HI : FIN;
            end
            F_HI: if (mem_rd_ack) begin
                lat_en[2] = 1'b1;
                state_n   = FIN;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
`ifdef OPSEQ_TIMEOUT_EN
        if (fetching && !mem_rd_ack && wd_cnt == 4'(TIMEOUT_CYC - 1)) begin
            state_n = IDLE;
            timeout = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            nimm_q    <= NEED_IMM_NONE;
            pc_hold   <= '0;
            disp_hold <= 8'h00;
            imm_hold  <= 16'h0000;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                addr   <= pc_in;
                nimm_q <= need_imm;
            end else if (fetching && mem_rd_ack) begin
                addr <= addr + ADDR_W'(1);
            end
            if (state == FIN) begin
                pc_hold   <= addr;
                disp_hold <= lat_q[0];
                imm_hold  <= {lat_q[2], lat_q[1]};
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_lat
        opseq_byte_latch u_lat (
            .clk (clk),
            .rst (rst),
            .clr (lat_clr),
            .en  (lat_en[i]),
            .d   (mem_rd_data),
            .q   (lat_q[i])
        );
    end

`ifdef OPSEQ_TIMEOUT_EN
    // Restarts on every new byte request (entry or ack), counts stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= timeout;
            if (!fetching || mem_rd_ack) wd_cnt <= 4'd0;
            else                         wd_cnt <= wd_cnt + 4'd1;
        end
    end
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign mem_rd_req  = fetching;
    assign mem_rd_addr = addr;
    assign busy        = (state != IDLE);
    assign done        = (state == FIN);
    assign pc_out      = done ? addr : pc_hold;
    assign disp        = done ? lat_q[0] : disp_hold;
    assign imm         = done ? {lat_q[2], lat_q[1]} : imm_hold;

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Self-checking bench for operand_fetch_sequencer. The driver schedules each
// fetch cycle by cycle and publishes what the outputs must be for that cycle;
// one compare process checks them at every falling edge.
module tb_operand_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        need_disp;
    logic [1:0]  need_imm;
    logic [15:0] pc_in;
    logic        mem_rd_req;
    logic [15:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic [7:0]  mem_rd_data;
    logic [15:0] pc_out;
    logic [7:0]  disp;
    logic [15:0] imm;
    logic        busy;
    logic        done;
    logic        fetch_err;

    operand_fetch_sequencer #(.ADDR_W(16), .TIMEOUT_CYC(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .need_disp   (need_disp),
        .need_imm    (need_imm),
        .pc_in       (pc_in),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_data (mem_rd_data),
        .pc_out      (pc_out),
        .disp        (disp),
        .imm         (imm),
        .busy        (busy),
        .done        (done),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Expected outputs for the current cycle.
    logic        exp_req, exp_busy, exp_done, exp_err;
    logic [15:0] exp_addr, exp_pc, exp_imm;
    logic [7:0]  exp_disp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_rd_req", 32'(mem_rd_req), 32'(exp_req));
            if (exp_req) chk("mem_rd_addr", 32'(mem_rd_addr), 32'(exp_addr));
            chk("busy",      32'(busy),      32'(exp_busy));
            chk("done",      32'(done),      32'(exp_done));
            chk("fetch_err", 32'(fetch_err), 32'(exp_err));
            chk("pc_out",    32'(pc_out),    32'(exp_pc));
            chk("disp",      32'(disp),      32'(exp_disp));
            chk("imm",       32'(imm),       32'(exp_imm));
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp;
        exp_req  = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Idle cycles with stray acks that must be ignored.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            start       = 1'b0;
            mem_rd_ack  = 1'($urandom_range(0, 1));
            mem_rd_data = 8'($urandom);
            set_idle_exp();
            step();
        end
        mem_rd_ack = 1'b0;
    endtask

    // One complete fetch. Bytes are supplied in fetch order (d, lo, hi as
    // needed); w* are wait cycles before each ack; junk drives stray start
    // pulses and scrambled request fields while busy.
    task automatic run_txn(input bit nd, input bit [1:0] ni, input logic [15:0] pc,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int w0, input int w1, input int w2, input bit junk);
        logic [7:0] dat[3];
        int         wt[3];
        int         nimm, nb, first;
        dat   = '{b0, b1, b2};
        wt    = '{w0, w1, w2};
        nimm  = (ni == 2'd0) ? 0 : (ni == 2'd1) ? 1 : 2;
        first = nd ? 1 : 0;
        nb    = first + nimm;
        // start cycle: sequencer still idle
        start = 1'b1; need_disp = nd; need_imm = ni; pc_in = pc; mem_rd_ack = 1'b0;
        set_idle_exp();
        step();
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k <= wt[i]; k++) begin
                start       = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                need_disp   = 1'($urandom);
                need_imm    = 2'($urandom);
                pc_in       = 16'($urandom);
                mem_rd_ack  = (k == wt[i]);
                mem_rd_data = (k == wt[i]) ? dat[i] : 8'($urandom);
                exp_req     = 1'b1;
                exp_addr    = pc + 16'(i);
                exp_busy    = 1'b1;
                exp_done    = 1'b0;
                step();
            end
        end
        // done cycle: new results visible
        start      = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rd_ack = 1'b0;
        exp_req    = 1'b0;
        exp_busy   = 1'b1;
        exp_done   = 1'b1;
        exp_pc     = pc + 16'(nb);
        exp_disp   = nd ? dat[0] : 8'h00;
        exp_imm    = {(nimm == 2) ? dat[first + 1] : 8'h00,
                      (nimm >= 1) ? dat[first]     : 8'h00};
        step();
        start = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; need_disp = 1'b0; need_imm = 2'd0; pc_in = 16'h0;
        mem_rd_ack = 1'b0; mem_rd_data = 8'h00;
        set_idle_exp();
        exp_addr = 16'h0; exp_pc = 16'h0; exp_disp = 8'h00; exp_imm = 16'h0000;
        step();
        chk_en = 1'b1;   // reset state checked from here on
        step();
        rst = 1'b0;
        idle(2);

        // nn, zero-wait: done three cycles after start
        run_txn(1'b0, 2'd2, 16'h1234, 8'hCD, 8'hAB, 8'h00, 0, 0, 0, 1'b0);
        chk("t1_imm", 32'(imm), 32'h0000_ABCD);
        chk("t1_pc",  32'(pc_out), 32'h0000_1236);
        idle(1);

        // d + n, two wait cycles per byte
        run_txn(1'b1, 2'd1, 16'h0100, 8'hFE, 8'h42, 8'h00, 2, 2, 0, 1'b0);
        chk("t2_disp", 32'(disp), 32'h0000_00FE);
        chk("t2_imm",  32'(imm),  32'h0000_0042);
        chk("t2_pc",   32'(pc_out), 32'h0000_0102);

        // no operand bytes
        run_txn(1'b0, 2'd0, 16'h5555, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b0);
        chk("t3_pc",  32'(pc_out), 32'h0000_5555);
        chk("t3_imm", 32'(imm), 32'h0);

        // address wrap
        run_txn(1'b0, 2'd2, 16'hFFFF, 8'h11, 8'h22, 8'h00, 1, 0, 0, 1'b0);
        chk("t4_pc",  32'(pc_out), 32'h0000_0001);
        chk("t4_imm", 32'(imm), 32'h0000_2211);
        idle(2);

        // reset while F_LO waits, with an ack arriving in the reset cycle
        start = 1'b1; need_disp = 1'b0; need_imm = 2'd2; pc_in = 16'h2000;
        set_idle_exp();
        step();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_req = 1'b1; exp_addr = 16'h2000; exp_busy = 1'b1;
            step();
        end
        rst = 1'b1; mem_rd_ack = 1'b1; mem_rd_data = 8'h77;
        step();
        rst = 1'b0; mem_rd_ack = 1'b0;
        set_idle_exp();
        exp_pc = 16'h0; exp_disp = 8'h00; exp_imm = 16'h0000;
        // reset and start together: reset wins
        rst = 1'b1; start = 1'b1; need_imm = 2'd1; pc_in = 16'h4444;
        step();
        rst = 1'b0; start = 1'b0;
        idle(1);

        // stray starts while busy; need_imm=3 behaves as 2
        run_txn(1'b1, 2'd3, 16'h8000, 8'h5A, 8'h34, 8'h12, 1, 3, 0, 1'b1);
        chk("t5_imm", 32'(imm), 32'h0000_1234);
        chk("t5_pc",  32'(pc_out), 32'h0000_8003);
        idle(1);

`ifdef OPSEQ_TIMEOUT_EN
        // read never acknowledged: error pulse after 15 request cycles
        start = 1'b1; need_disp = 1'b0; need_imm = 2'd1; pc_in = 16'h3000;
        set_idle_exp();
        step();
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            exp_req = 1'b1; exp_addr = 16'h3000; exp_busy = 1'b1;
            step();
        end
        set_idle_exp();
        exp_err = 1'b1;
        step();
        exp_err = 1'b0;
        idle(2);
`endif

        // randomized fetches
        for (int t = 0; t < 60; t++) begin
            logic [15:0] pc;
            pc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFD + $urandom_range(0, 2))
                                             : 16'($urandom);
            run_txn(1'($urandom), 2'($urandom), pc,
                    8'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom));
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_fetch_sequencer.md
Name: operand_fetch_sequencer

Overview:
- Sequences the memory reads for the bytes that follow an opcode: displacement d, immediate n, or address/immediate nn low and high bytes.
- Decode raises one start strobe carrying the fetch requirements. This replaces the static per-instruction "need next byte" OR-flags with one sequenced controller.
- Drives the memory read handshake, increments PC once per byte, latches the bytes and pulses done to the execute stage.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- TIMEOUT_CYC, 15, watchdog limit in cycles; used only with OPSEQ_TIMEOUT_EN.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle strobe from decode; sampled only in IDLE.
- need_disp  input  1  fetch displacement byte d first (IX/IY+d forms).
- need_imm  input  2  immediate bytes after d: 0, 1 (n) or 2 (nn, low then high); value 3 is treated as 2.
- pc_in  input  ADDR_W  address of the first operand byte, sampled with start.
- mem_rd_req  output  1  read request; held high until acknowledged.
- mem_rd_addr  output  ADDR_W  read address; stable while mem_rd_req is high.
- mem_rd_ack  input  1  read data valid this cycle.
- mem_rd_data  input  8  read data.
- pc_out  output  ADDR_W  address following the last fetched byte.
- disp  output  8  latched displacement.
- imm  output  16  latched immediate; {hi, lo}, hi is 0 when need_imm=1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when all bytes are latched.
- fetch_err  output  1  watchdog expiry pulse; constant 0 without the option.

Behaviour:
- Reset values: all outputs 0 and state IDLE.
- States: IDLE, F_DISP, F_LO, F_HI, FIN.
- IDLE:
  - start with need_disp=1 -> F_DISP.
  - start with need_disp=0 and need_imm>0 -> F_LO.
  - start with need_disp=0 and need_imm=0 -> FIN, with no memory access and pc_out=pc_in.
- Entry into any fetch state: in the same edge, mem_rd_req=1 and mem_rd_addr=current address.
- Ack handling: on mem_rd_ack, latch the byte, increment the address (mod 2^ADDR_W), then:
  - drop mem_rd_req for at least one cycle, or
  - re-assert it on the next edge for the following byte (back-to-back is allowed).
- Transitions on ack:
  - F_DISP -> F_LO if need_imm>0, else FIN.
  - F_LO -> F_HI if need_imm>=2, else FIN.
  - F_HI -> FIN.
- FIN: done=1 for one cycle with disp, imm and pc_out valid, then IDLE. Outputs hold until the next start.
- Minimum latency: start to done = bytes+1 cycles with zero-wait acks (ack in the first request cycle).
- Boundary rules:
  - start while busy is ignored.
  - mem_rd_ack while mem_rd_req is low is ignored.
  - The address wraps FFFF -> 0000.
  - need_imm, need_disp and pc_in are captured at start; later changes have no effect.
  - rst mid-fetch: mem_rd_req drops on the next edge, all outputs return to 0, and the pending ack is discarded.
  - rst and start in the same cycle: rst wins.

Optional Feature:
- Macro: OPSEQ_TIMEOUT_EN.
- With the macro defined:
  - A 4-bit counter clears on each request assertion and counts while mem_rd_req=1 and mem_rd_ack=0.
  - Reaching TIMEOUT_CYC pulses fetch_err for one cycle, drops mem_rd_req and returns to IDLE without done. pc_out, disp and imm keep their previous values.
- Without the macro: the counter is absent, fetch_err is tied to 0, and the sequencer waits indefinitely.

Decomposition:
- Shared package: state encoding constants (IDLE=0, F_DISP=1, F_LO=2, F_HI=3, FIN=4) and the NEED_IMM_NONE/N/NN codes, shared with the decoder.
- One sub-module, opseq_byte_latch: a per-byte capture register with enable and synchronous clear.

Test Plan:
- need_disp=0, need_imm=2, pc_in=0x1234, data 0xCD then 0xAB, zero-wait ack -> addresses 0x1234, 0x1235; imm=0xABCD, pc_out=0x1236, done 3 cycles after start.
- need_disp=1, need_imm=1, pc_in=0x0100, data 0xFE, 0x42, acks delayed 2 cycles each -> disp=0xFE, imm=0x0042, pc_out=0x0102; mem_rd_addr stable during waits.
- need_disp=0, need_imm=0, pc_in=0x5555 -> done on the cycle after start, no mem_rd_req, pc_out=0x5555.
- pc_in=0xFFFF, need_imm=2 -> addresses 0xFFFF then 0x0000; pc_out=0x0001.
- rst asserted while F_LO is waiting -> mem_rd_req=0 and busy=0 next cycle; a following start behaves normally; a second start pulsed while busy is ignored.
- OPSEQ_TIMEOUT_EN, TIMEOUT_CYC=15, never ack -> fetch_err pulse 15 cycles after the request, no done, back in IDLE.
